// File: rtl/lcd_bus_reader.sv
// Read-side HD44780 bus sequencer: runs single RW=1 read cycles (status or data)
// and can poll the busy flag until it clears or a read-count limit is hit.
module lcd_bus_reader #(
  parameter int SETUP_CYC   = 3,
  parameter int EN_HIGH_CYC = 16,
  parameter int HOLD_CYC    = 3,
  parameter int EN_LOW_CYC  = 25,
  parameter int POLL_LIMIT  = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       rs_sel,
  input  logic       poll,
  input  logic [7:0] lcd_data_i,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       timeout,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en
);

  localparam int MAX_SH  = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int MAX_EL  = (EN_HIGH_CYC > EN_LOW_CYC) ? EN_HIGH_CYC : EN_LOW_CYC;
  localparam int MAX_CYC = (MAX_SH > MAX_EL) ? MAX_SH : MAX_EL;
  // The counter only ever holds a duration minus one, so it never needs MAX_CYC itself.
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_HI_LD  = CNT_W'(EN_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LO_LD  = CNT_W'(EN_LOW_CYC - 1);
  localparam logic [15:0]      LIMIT     = 16'(POLL_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_EN_HI,
    S_HOLD,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      poll_cnt_q;
  logic [7:0]       sample_q;
  logic [7:0]       rd_data_q;
  logic             poll_q;
  logic             busy_q;
  logic             done_q;
  logic             timeout_q;
  logic             rs_q;
  logic             rw_q;
  logic             en_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      poll_cnt_q <= '0;
      sample_q   <= '0;
      rd_data_q  <= '0;
      poll_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      rs_q       <= 1'b0;
      rw_q       <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req) begin
            state_q    <= S_SETUP;
            cnt_q      <= SETUP_LD;
            busy_q     <= 1'b1;
            rw_q       <= 1'b1;
            rs_q       <= rs_sel;
            poll_q     <= poll & ~rs_sel;
            timeout_q  <= 1'b0;
            poll_cnt_q <= '0;
          end
        end
        S_SETUP: begin
          if (cnt_q == '0) begin
            state_q <= S_EN_HI;
            cnt_q   <= EN_HI_LD;
            en_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_EN_HI: begin
          if (cnt_q == '0) begin
            state_q    <= S_HOLD;
            cnt_q      <= HOLD_LD;
            en_q       <= 1'b0;
            sample_q   <= lcd_data_i;
            poll_cnt_q <= poll_cnt_q + 16'd1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt_q == '0) begin
            if (poll_q && sample_q[7] && (poll_cnt_q < LIMIT)) begin
              state_q <= S_GAP;
              cnt_q   <= EN_LO_LD;
            end else begin
              // Still busy here means the read budget ran out.
              state_q   <= S_DONE;
              done_q    <= 1'b1;
              rd_data_q <= sample_q;
              timeout_q <= poll_q & sample_q[7];
              rw_q      <= 1'b0;
              rs_q      <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_GAP: begin
          if (cnt_q == '0) begin
            state_q <= S_SETUP;
            cnt_q   <= SETUP_LD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_data = rd_data_q;
  assign timeout = timeout_q;
  assign lcd_rs  = rs_q;
  assign lcd_rw  = rw_q;
  assign lcd_en  = en_q;

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Directed bench for lcd_bus_reader: default-parameter instance plus a
// POLL_LIMIT=4 instance for the timeout path, selected through a local mux.
module tb_lcd_bus_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic       rs_sel = 1'b0;
  logic       poll = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] data = 8'h00;

  always #10 clk = ~clk;

  logic       req_a, req_b;
  logic       busy_a, done_a, to_a, rs_a, rw_a, en_a;
  logic       busy_b, done_b, to_b, rs_b, rw_b, en_b;
  logic [7:0] rd_a, rd_b;

  assign req_a = req & ~sel;
  assign req_b = req & sel;

  lcd_bus_reader u_dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .rs_sel(rs_sel), .poll(poll),
    .lcd_data_i(data), .busy(busy_a), .done(done_a), .rd_data(rd_a),
    .timeout(to_a), .lcd_rs(rs_a), .lcd_rw(rw_a), .lcd_en(en_a)
  );

  lcd_bus_reader #(.POLL_LIMIT(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .rs_sel(rs_sel), .poll(poll),
    .lcd_data_i(data), .busy(busy_b), .done(done_b), .rd_data(rd_b),
    .timeout(to_b), .lcd_rs(rs_b), .lcd_rw(rw_b), .lcd_en(en_b)
  );

  logic       o_busy, o_done, o_to, o_rs, o_rw, o_en;
  logic [7:0] o_rd;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_done = sel ? done_b : done_a;
  assign o_to   = sel ? to_b   : to_a;
  assign o_rs   = sel ? rs_b   : rs_a;
  assign o_rw   = sel ? rw_b   : rw_a;
  assign o_en   = sel ? en_b   : en_a;
  assign o_rd   = sel ? rd_b   : rd_a;

  int passes = 0;
  int total  = 0;
  int fails  = 0;

  int         done_cnt, done_cyc, pulses, en_first, en_last, rsrw_bad, busy_after;
  logic [7:0] done_rd;
  logic       done_to, done_rwrs, to_c1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive req for one edge (edge 0 of the transaction).
  task automatic start(input logic rs, input logic p);
    @(negedge clk);
    rs_sel = rs;
    poll   = p;
    req    = 1'b1;
    @(posedge clk);
  endtask

  // Watch cycles 1..n after edge 0; optional extra req pulses and busy-flag bus model.
  task automatic observe(input int n, input logic exp_rs, input int req_c1,
                         input int req_c2, input bit bf_model);
    logic prev_en;
    prev_en    = 1'b0;
    done_cnt   = 0;
    done_cyc   = -1;
    pulses     = 0;
    en_first   = -1;
    en_last    = -1;
    rsrw_bad   = 0;
    busy_after = 0;
    done_rd    = 8'h00;
    done_to    = 1'b0;
    done_rwrs  = 1'b1;
    to_c1      = 1'b1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      req = (k == req_c1) || (k == req_c2);
      if (o_en && !prev_en) begin
        pulses++;
        if (en_first < 0) en_first = k;
      end
      if (o_en) en_last = k;
      if (!o_en && prev_en && bf_model) data = (pulses < 3) ? 8'h85 : 8'h05;
      prev_en = o_en;
      if (k == 1) to_c1 = o_to;
      if (done_cnt == 0 && !o_done && !(o_rw && o_rs == exp_rs)) rsrw_bad++;
      if (o_done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_cyc  = k;
          done_rd   = o_rd;
          done_to   = o_to;
          done_rwrs = o_rw | o_rs;
        end
      end else if (done_cnt > 0 && o_busy) begin
        busy_after++;
      end
    end
    req = 1'b0;
  endtask

  initial begin
    int dseen;

    // Reset state
    #25;
    check("reset_outputs", 32'({o_busy, o_done, o_to, o_rs, o_rw, o_en, o_rd}), 0);
    check("reset_outputs_b", 32'({busy_b, done_b, to_b, rs_b, rw_b, en_b, rd_b}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single data read
    data = 8'h41;
    start(1'b1, 1'b0);
    observe(30, 1'b1, 0, 0, 1'b0);
    check("single_done_cycle", done_cyc, 23);
    check("single_done_count", done_cnt, 1);
    check("single_rd_data", 32'(done_rd), 32'h41);
    check("single_timeout", 32'(done_to), 0);
    check("single_en_pulses", pulses, 1);
    check("single_en_first", en_first, 4);
    check("single_en_last", en_last, 19);
    check("single_rs_rw_stable", rsrw_bad, 0);
    check("single_rs_rw_at_done", 32'(done_rwrs), 0);
    check("single_busy_after", busy_after, 0);

    // Busy poll: BF set for three reads, then clear
    data = 8'h85;
    start(1'b0, 1'b1);
    observe(175, 1'b0, 0, 0, 1'b1);
    check("poll_done_cycle", done_cyc, 164);
    check("poll_en_pulses", pulses, 4);
    check("poll_rd_data", 32'(done_rd), 32'h05);
    check("poll_timeout", 32'(done_to), 0);
    check("poll_rs_rw_stable", rsrw_bad, 0);

    // Poll timeout on the POLL_LIMIT=4 instance
    sel  = 1'b1;
    data = 8'h80;
    start(1'b0, 1'b1);
    observe(175, 1'b0, 0, 0, 1'b0);
    check("tmo_en_pulses", pulses, 4);
    check("tmo_done_cycle", done_cyc, 164);
    check("tmo_timeout", 32'(done_to), 1);
    check("tmo_rd_data", 32'(done_rd), 32'h80);

    data = 8'h3C;
    start(1'b1, 1'b0);
    observe(30, 1'b1, 0, 0, 1'b0);
    check("tmo_clear_at_accept", 32'(to_c1), 0);
    check("tmo_next_rd_data", 32'(done_rd), 32'h3C);
    check("tmo_next_timeout", 32'(done_to), 0);
    sel = 1'b0;

    // Requests during a transaction and in the DONE cycle are ignored
    data = 8'h55;
    start(1'b1, 1'b0);
    observe(60, 1'b1, 5, 23, 1'b0);
    check("ign_done_count", done_cnt, 1);
    check("ign_done_cycle", done_cyc, 23);
    check("ign_busy_after", busy_after, 0);
    check("ign_en_pulses", pulses, 1);

    // poll with rs_sel=1 is a single read even with bit 7 set
    data = 8'hC3;
    start(1'b1, 1'b1);
    observe(30, 1'b1, 0, 0, 1'b0);
    check("pollrs_done_cycle", done_cyc, 23);
    check("pollrs_en_pulses", pulses, 1);
    check("pollrs_rd_data", 32'(done_rd), 32'hC3);

    // Reset during E high
    data = 8'h99;
    start(1'b1, 1'b0);
    @(negedge clk);
    req = 1'b0;
    repeat (9) @(negedge clk);
    check("rst_en_high_before", 32'(o_en), 1);
    rst_n = 1'b0;
    #1;
    check("rst_async_outputs", 32'({o_en, o_rw, o_busy, o_rs}), 0);
    dseen = 0;
    repeat (30) begin
      @(negedge clk);
      if (o_done) dseen++;
    end
    check("rst_no_done", dseen, 0);
    check("rst_rd_data_lost", 32'(o_rd), 0);
    @(negedge clk);
    rst_n = 1'b1;

    data = 8'h2A;
    start(1'b1, 1'b0);
    observe(30, 1'b1, 0, 0, 1'b0);
    check("post_rst_done_cycle", done_cyc, 23);
    check("post_rst_rd_data", 32'(done_rd), 32'h2A);
    check("post_rst_timeout", 32'(done_to), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
